// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 slave that turns host byte frames into a clk-domain register bus.
// Define SPI_REG_AUTOINC_EN to step regnum after every burst write and every read reload.
module spi_reg_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic [6:0] regnum,
    input  logic [7:0] regdata_read,
    output logic [7:0] regdata_write,
    output logic       read,
    output logic       write
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_DATA
    } state_t;

`ifdef SPI_REG_AUTOINC_EN
    localparam logic [6:0] REG_STEP = 7'd1;
`else
    localparam logic [6:0] REG_STEP = 7'd0;
`endif

    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;

    state_t     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] regnum_q, regnum_d;
    logic [7:0] wdata_q, wdata_d;
    logic       read_q, read_d;
    logic       write_q, write_d;
    logic       miso_q, miso_d;
    logic       armed_q, armed_d;

    logic       ss_s, sck_s, mosi_s;
    logic       sck_rise, sck_fall, byte_done;
    logic [7:0] byte_in;

    // Synchronizer shift chains and sck edge detection on the synced copy
    always_comb begin
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ss_s        = ss_sync_q[SYNC_STAGES-1];
        sck_s       = sck_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sck_prev_d  = sck_s;
        sck_rise    = sck_s & ~sck_prev_q;
        sck_fall    = ~sck_s & sck_prev_q;
        byte_in     = {rx_q[6:0], mosi_s};
        byte_done   = sck_rise && (bitcnt_q == 3'd7);
    end

    // Frame sequencing: byte assembly, strobes, regnum updates and miso shifting
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        regnum_d = regnum_q;
        wdata_d  = wdata_q;
        read_d   = 1'b0;
        write_d  = 1'b0;
        // A frame may only start after ss has been seen high, so a reset
        // in the middle of a frame ignores the remainder of that frame.
        armed_d  = armed_q | ss_s;

        if (read_q) begin
            tx_d = regdata_read;
        end
        if (write_q) begin
            regnum_d = regnum_q + REG_STEP;
        end

        if (ss_s) begin
            state_d  = IDLE;
            bitcnt_d = 3'd0;
            rx_d     = 8'h00;
        end else if (state_q == IDLE) begin
            if (armed_q) begin
                state_d = CMD;
            end
        end else begin
            if (sck_rise) begin
                bitcnt_d = bitcnt_q + 3'd1;
                rx_d     = byte_in;
            end
            // The fall that follows a completed byte keeps the fresh MSB
            if (state_q == RD_DATA && sck_fall && bitcnt_q != 3'd0 && !read_q) begin
                tx_d = {tx_q[6:0], 1'b0};
            end
            if (byte_done) begin
                unique case (state_q)
                    CMD: begin
                        regnum_d = byte_in[6:0];
                        tx_d     = 8'h00;
                        if (byte_in[7]) begin
                            state_d = WR_DATA;
                        end else begin
                            state_d = RD_DATA;
                            read_d  = 1'b1;
                        end
                    end
                    WR_DATA: begin
                        wdata_d = byte_in;
                        write_d = 1'b1;
                    end
                    RD_DATA: begin
                        regnum_d = regnum_q + REG_STEP;
                        read_d   = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end

        miso_d = (state_d == RD_DATA) ? tx_d[7] : 1'b0;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_q   <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            state_q     <= IDLE;
            bitcnt_q    <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            regnum_q    <= 7'd0;
            wdata_q     <= 8'h00;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            miso_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            ss_sync_q   <= ss_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            regnum_q    <= regnum_d;
            wdata_q     <= wdata_d;
            read_q      <= read_d;
            write_q     <= write_d;
            miso_q      <= miso_d;
            armed_q     <= armed_d;
        end
    end

    assign miso          = miso_q;
    assign regnum        = regnum_q;
    assign regdata_write = wdata_q;
    assign read          = read_q;
    assign write         = write_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: drives SPI frames into spi_reg_slave and checks the register bus
// against a byte-level frame model. Honours SPI_REG_AUTOINC_EN like the design.
`timescale 1ns/1ps
module tb_spi_reg_slave;

    localparam int H = 4;
`ifdef SPI_REG_AUTOINC_EN
    localparam int INC = 1;
`else
    localparam int INC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, ss, sck, mosi, miso, read, write;
    logic [6:0] regnum;
    logic [7:0] regdata_read, regdata_write;

    logic [7:0]  mem [128];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  fb[$];
    logic [7:0]  got_miso[$];
    logic [14:0] wq[$];
    logic [6:0]  rq[$];
    bit          both_seen = 1'b0;
    logic [14:0] ewq[$];
    logic [6:0]  erq[$];
    logic [7:0]  emiso[$];
    logic [6:0]  model_reg;
    logic [7:0]  model_wd;

    always #5 clk = ~clk;

    assign regdata_read = mem[regnum];

    spi_reg_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso),
        .regnum(regnum), .regdata_read(regdata_read), .regdata_write(regdata_write),
        .read(read), .write(write)
    );

    always @(negedge clk) begin
        if (write) wq.push_back({regnum, regdata_write});
        if (read) rq.push_back(regnum);
        if (read && write) both_seen = 1'b1;
    end

    task automatic clear_q();
        wq.delete(); rq.delete(); got_miso.delete();
        ewq.delete(); erq.delete(); emiso.delete();
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            repeat (H) @(negedge clk);
            sck = 1'b1;
            mi[i] = miso;
            repeat (H) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input int partial);
        logic [7:0] m;
        logic [7:0] pb;
        ss = 1'b0;
        repeat (6) @(negedge clk);
        foreach (fb[k]) begin
            xfer_bits(fb[k], 8, m);
            got_miso.push_back(m);
        end
        if (partial > 0) begin
            pb = 8'($urandom);
            xfer_bits(pb, partial, m);
        end
        repeat (H) @(negedge clk);
        ss = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Byte-level frame model: command byte picks register and direction,
    // each later full byte is one write or one read reload.
    task automatic model_frame();
        logic [6:0] r;
        if (fb.size() == 0) return;
        r = fb[0][6:0];
        emiso.push_back(8'h00);
        if (fb[0][7]) begin
            for (int i = 1; i < fb.size(); i++) begin
                ewq.push_back({r, fb[i]});
                model_wd = fb[i];
                emiso.push_back(8'h00);
                r = r + 7'(INC);
            end
        end else begin
            erq.push_back(r);
            for (int i = 1; i < fb.size(); i++) begin
                emiso.push_back(mem[r]);
                r = r + 7'(INC);
                erq.push_back(r);
            end
        end
        model_reg = r;
    endtask

    task automatic test_reset();
        rst = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (miso !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes miso=%b read=%b write=%b expected 0", miso, read, write);
        end
        checks++;
        if (regnum !== 7'h00 || regdata_write !== 8'h00) begin
            failures++;
            $display("FAIL reset_regs regnum=%h wdata=%h expected 00/00", regnum, regdata_write);
        end
    endtask

    task automatic test_write();
        clear_q();
        fb = '{8'h8D, 8'h5A};
        run_frame(0);
        checks++;
        if (wq.size() != 1 || wq[0] !== {7'h0D, 8'h5A}) begin
            failures++;
            $display("FAIL write_single n=%0d got=%h expected 1 x %h", wq.size(), wq[0], {7'h0D, 8'h5A});
        end
        checks++;
        if (rq.size() != 0 || got_miso[0] !== 8'h00 || got_miso[1] !== 8'h00) begin
            failures++;
            $display("FAIL write_noread reads=%0d miso=%h,%h expected 0/00,00", rq.size(), got_miso[0], got_miso[1]);
        end
        checks++;
        if (regnum !== 7'(13 + INC) || regdata_write !== 8'h5A) begin
            failures++;
            $display("FAIL write_final regnum=%h wdata=%h expected %h/5a", regnum, regdata_write, 7'(13 + INC));
        end
    endtask

    task automatic test_read();
        clear_q();
        mem[0] = 8'h10;
        fb = '{8'h00, 8'hFF};
        run_frame(0);
        checks++;
        if (got_miso[0] !== 8'h00 || got_miso[1] !== 8'h10) begin
            failures++;
            $display("FAIL read_miso got=%h,%h expected 00,10", got_miso[0], got_miso[1]);
        end
        checks++;
        if (rq.size() != 2 || rq[0] !== 7'h00 || rq[1] !== 7'(INC) || wq.size() != 0) begin
            failures++;
            $display("FAIL read_strobes reads=%0d first=%h second=%h writes=%0d expected 2/00/%h/0",
                     rq.size(), rq[0], rq[1], wq.size(), 7'(INC));
        end
    endtask

    task automatic test_burst();
        clear_q();
        fb = '{8'h85, 8'h11, 8'h22};
        run_frame(0);
        checks++;
        if (wq.size() != 2 || wq[0] !== {7'h05, 8'h11} || wq[1] !== {7'(5 + INC), 8'h22}) begin
            failures++;
            $display("FAIL burst_writes n=%0d got=%h,%h expected %h,%h",
                     wq.size(), wq[0], wq[1], {7'h05, 8'h11}, {7'(5 + INC), 8'h22});
        end
        checks++;
        if (regnum !== 7'(5 + 2 * INC)) begin
            failures++;
            $display("FAIL burst_regnum got=%h expected %h", regnum, 7'(5 + 2 * INC));
        end
    endtask

    task automatic test_wrap();
        logic [6:0] nxt;
        nxt = 7'h7F + 7'(INC);
        clear_q();
        fb = '{8'hFF, 8'hAA, 8'hBB};
        run_frame(0);
        checks++;
        if (wq.size() != 2 || wq[0] !== {7'h7F, 8'hAA} || wq[1] !== {nxt, 8'hBB}) begin
            failures++;
            $display("FAIL wrap_writes n=%0d got=%h,%h expected %h,%h",
                     wq.size(), wq[0], wq[1], {7'h7F, 8'hAA}, {nxt, 8'hBB});
        end
    endtask

    task automatic test_abort();
        clear_q();
        fb = '{8'h8D};
        run_frame(4);
        checks++;
        if (wq.size() != 0 || rq.size() != 0 || regnum !== 7'h0D || regdata_write !== 8'hBB) begin
            failures++;
            $display("FAIL abort_hold writes=%0d reads=%0d regnum=%h wdata=%h expected 0/0/0d/bb",
                     wq.size(), rq.size(), regnum, regdata_write);
        end
        clear_q();
        fb = '{8'h8D, 8'h33};
        run_frame(0);
        checks++;
        if (wq.size() != 1 || wq[0] !== {7'h0D, 8'h33}) begin
            failures++;
            $display("FAIL abort_recover n=%0d got=%h expected 1 x %h", wq.size(), wq[0], {7'h0D, 8'h33});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        logic [7:0] acc;
        clear_q();
        ss = 1'b0;
        repeat (6) @(negedge clk);
        xfer_bits(8'h05, 8, m);
        xfer_bits(8'hA5, 3, m);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (miso !== 1'b0 || read !== 1'b0 || write !== 1'b0 || regnum !== 7'h00 || regdata_write !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_outputs miso=%b read=%b write=%b regnum=%h wdata=%h expected all 0",
                     miso, read, write, regnum, regdata_write);
        end
        rst = 1'b0;
        wq.delete(); rq.delete();
        xfer_bits(8'hA5, 5, m);
        acc = m;
        xfer_bits(8'h8E, 8, m);
        acc = acc | m;
        xfer_bits(8'h77, 8, m);
        acc = acc | m;
        repeat (H) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (wq.size() != 0 || rq.size() != 0 || acc !== 8'h00 || regnum !== 7'h00) begin
            failures++;
            $display("FAIL rst_mid_ignore writes=%0d reads=%0d miso_or=%h regnum=%h expected 0/0/00/00",
                     wq.size(), rq.size(), acc, regnum);
        end
        clear_q();
        fb = '{8'h8D, 8'h33};
        run_frame(0);
        checks++;
        if (wq.size() != 1 || wq[0] !== {7'h0D, 8'h33}) begin
            failures++;
            $display("FAIL rst_mid_recover n=%0d got=%h expected 1 x %h", wq.size(), wq[0], {7'h0D, 8'h33});
        end
        model_wd = 8'h33;
    endtask

    task automatic test_random();
        int n;
        int part;
        for (int f = 0; f < 24; f++) begin
            clear_q();
            fb.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
            if (f % 6 == 5) fb[0][6:0] = 7'h7E;
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            model_frame();
            run_frame(part);
            checks++;
            if (wq.size() != ewq.size()) begin
                failures++;
                $display("FAIL rand%0d_write_count got=%0d expected %0d", f, wq.size(), ewq.size());
            end else begin
                foreach (ewq[i]) begin
                    checks++;
                    if (wq[i] !== ewq[i]) begin
                        failures++;
                        $display("FAIL rand%0d_write%0d got=%h expected %h", f, i, wq[i], ewq[i]);
                    end
                end
            end
            checks++;
            if (rq.size() != erq.size()) begin
                failures++;
                $display("FAIL rand%0d_read_count got=%0d expected %0d", f, rq.size(), erq.size());
            end else begin
                foreach (erq[i]) begin
                    checks++;
                    if (rq[i] !== erq[i]) begin
                        failures++;
                        $display("FAIL rand%0d_read%0d regnum got=%h expected %h", f, i, rq[i], erq[i]);
                    end
                end
            end
            foreach (emiso[i]) begin
                checks++;
                if (got_miso[i] !== emiso[i]) begin
                    failures++;
                    $display("FAIL rand%0d_miso%0d got=%h expected %h", f, i, got_miso[i], emiso[i]);
                end
            end
            checks++;
            if (regnum !== model_reg || regdata_write !== model_wd) begin
                failures++;
                $display("FAIL rand%0d_final regnum=%h wdata=%h expected %h/%h",
                         f, regnum, regdata_write, model_reg, model_wd);
            end
        end
        checks++;
        if (both_seen !== 1'b0) begin
            failures++;
            $display("FAIL strobe_overlap read and write high together got=%b expected 0", both_seen);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_burst();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
